// File: rtl/serial_word_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_feeder_pkg
// Description : Shared types and constants for the bit-serial
//               two's-complement path (feeder, complementer, deserialiser).
// Revision    : 1.0 - initial release
// ============================================================================
package serial_word_feeder_pkg;

    // Default word width used across the serial path
    localparam int WORD_W = 8;

    // Feeder control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_word_feeder_hold.sv
`default_nettype none
// ============================================================================
// Module      : word_hold_reg
// Description : One-word holding register with full flag. A load captures
//               the word and sets full; an unload clears full.
// Revision    : 1.0 - initial release
// ============================================================================
module word_hold_reg
    import serial_word_feeder_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_unload,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full
);

    logic [W-1:0] r_data;
    logic         r_full;

    // Capture on load; load wins over unload so a same-edge refill stays full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule
`default_nettype wire

// File: rtl/serial_word_feeder.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_feeder
// Description : Accepts parallel words over valid/ready and shifts them out
//               LSB-first with sof/eof framing. A holding register lets the
//               next word follow the current one without an idle slot.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_feeder
    import serial_word_feeder_pkg::*;
#(
    parameter int W   = WORD_W,
    parameter int GAP = 0
) (
    input  logic         t_clock,
    input  logic         r,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         x_out,
    output logic         bit_valid,
    output logic         sof,
    output logic         eof
);

    localparam int                  c_CW       = $clog2(W);
    localparam int                  c_GAP_CW   = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [c_CW-1:0]     c_LAST_BIT = c_CW'(W - 1);
    localparam logic [c_GAP_CW-1:0] c_GAP_LAST = c_GAP_CW'((GAP > 0) ? GAP - 1 : 0);

    feeder_state_t         r_state;
    feeder_state_t         w_state_next;
    logic [W-1:0]          r_shift;
    logic [W-1:0]          w_shift_next;
    logic [c_CW-1:0]       r_bit_cnt;
    logic [c_CW-1:0]       w_bit_cnt_next;
    logic [c_GAP_CW-1:0]   r_gap_cnt;
    logic [c_GAP_CW-1:0]   w_gap_cnt_next;
    logic                  r_din_ready;
    logic                  r_x_out;
    logic                  r_bit_valid;
    logic                  r_sof;
    logic                  r_eof;
    logic                  w_accept;
    logic                  w_hold_load;
    logic                  w_hold_unload;
    logic                  w_hold_full;
    logic                  w_hold_full_next;
    logic [W-1:0]          w_hold_data;

    assign w_accept = din_valid & r_din_ready;

    word_hold_reg #(
        .W (W)
    ) u_hold (
        .clk      (t_clock),
        .rst      (r),
        .i_load   (w_hold_load),
        .i_unload (w_hold_unload),
        .i_data   (din),
        .o_data   (w_hold_data),
        .o_full   (w_hold_full)
    );

    // Hold occupancy after this edge; din_ready is registered from it
    assign w_hold_full_next = w_hold_load | (w_hold_full & ~w_hold_unload);

    // Next-state, shifter and counter update; the hold reg is drained before din
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_gap_cnt_next = r_gap_cnt;
        w_hold_load    = 1'b0;
        w_hold_unload  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next   = ST_SHIFT;
                    w_shift_next   = din;
                    w_bit_cnt_next = '0;
                end
            end
            ST_SHIFT: begin
                if (r_bit_cnt == c_LAST_BIT) begin
                    if (GAP > 0) begin
                        w_state_next   = ST_GAP;
                        w_gap_cnt_next = '0;
                        w_hold_load    = w_accept;
                    end else if (w_hold_full) begin
                        w_shift_next   = w_hold_data;
                        w_hold_unload  = 1'b1;
                        w_bit_cnt_next = '0;
                    end else if (w_accept) begin
                        w_shift_next   = din;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_state_next   = ST_IDLE;
                    end
                end else begin
                    w_shift_next   = r_shift >> 1;
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    w_hold_load    = w_accept;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    if (w_hold_full) begin
                        w_state_next   = ST_SHIFT;
                        w_shift_next   = w_hold_data;
                        w_hold_unload  = 1'b1;
                        w_bit_cnt_next = '0;
                    end else if (w_accept) begin
                        w_state_next   = ST_SHIFT;
                        w_shift_next   = din;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_state_next   = ST_IDLE;
                    end
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 1'b1;
                    w_hold_load    = w_accept;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge t_clock) begin
        if (r) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and registered outputs, derived from the values entering each flop
    always_ff @(posedge t_clock) begin
        if (r) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_din_ready <= 1'b0;
            r_x_out     <= 1'b0;
            r_bit_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
        end else begin
            r_shift     <= w_shift_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_gap_cnt   <= w_gap_cnt_next;
            r_din_ready <= ~w_hold_full_next;
            r_x_out     <= (w_state_next == ST_SHIFT) & w_shift_next[0];
            r_bit_valid <= (w_state_next == ST_SHIFT);
            r_sof       <= (w_state_next == ST_SHIFT) & (w_bit_cnt_next == '0);
            r_eof       <= (w_state_next == ST_SHIFT) & (w_bit_cnt_next == c_LAST_BIT);
        end
    end

    assign din_ready = r_din_ready;
    assign x_out     = r_x_out;
    assign bit_valid = r_bit_valid;
    assign sof       = r_sof;
    assign eof       = r_eof;

endmodule
`default_nettype wire
